seven_seg_scanner: RTL and testbench

- Parametrised, time-multiplexed hex driver for a multi-digit common-anode 7-segment display.
- Holds a double-buffered hex word, scans one digit per refresh slot and drives shared active-low segment lines plus per-digit active-low anode enables.
- Inserts a guard (ghost-suppression) interval at the start of each slot.
- Sits between datapath debug registers (PC, ALU result) and the board display pins.

---
 rtl/seven_seg_scanner_if.sv | 24 ++
 rtl/seven_seg_scanner.sv | 124 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Bundle between a debug-value source and the 7-segment scanner.
// Master drives value/control; slave returns the pin-level scan outputs.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [2:0]              digit_idx;
    logic                    frame_start;

    modport master (
        output enable, load, value, dp_mask,
        input  seg, an, digit_idx, frame_start
    );

    modport slave (
        input  enable, load, value, dp_mask,
        output seg, an, digit_idx, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed, double-buffered hex driver for a common-anode display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 16
) (
    input logic clk,
    input logic rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
    localparam logic [2:0]    D_LAST  = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]         prescaler;
    logic [2:0]            idx;
    logic [VW-1:0]         pend_val;
    logic [VW-1:0]         disp_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  pend_valid;
    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  fs_q;

    logic                  tick;
    logic                  wrap;
    logic                  show;
    logic                  lead;
    logic [31:0]           val_pad;
    logic [7:0]            dp_pad;
    logic [7:0]            blank_pad;
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] an_sel;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (prescaler == P_LAST);
    assign wrap = tick && (idx == D_LAST);

    always_comb begin
        val_pad   = 32'(disp_val);
        dp_pad    = 8'(disp_dp);
        nib       = val_pad[{idx, 2'b00} +: 4];
        an_sel    = ~(NUM_DIGITS'(1) << idx);
        blank_pad = '0;
        lead      = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        // Padding above NUM_DIGITS is zero, so the run starts blank there.
        for (int k = 7; k >= 1; k--) begin
            lead = lead && (val_pad[4*k +: 4] == 4'h0) && !dp_pad[k];
            blank_pad[k] = lead;
        end
`endif
        show = bus.enable && (prescaler >= P_GUARD) && !blank_pad[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            pend_val   <= '0;
            disp_val   <= '0;
            pend_dp    <= '0;
            disp_dp    <= '0;
            pend_valid <= 1'b0;
            seg_q      <= 8'hFF;
            an_q       <= '1;
            fs_q       <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                idx <= (idx == D_LAST) ? 3'd0 : idx + 3'd1;
            fs_q <= wrap;

            // Display only changes on a frame wrap, so a frame never tears.
            if (bus.load && wrap) begin
                disp_val   <= bus.value;
                disp_dp    <= bus.dp_mask;
                pend_valid <= 1'b0;
            end else if (bus.load) begin
                pend_val   <= bus.value;
                pend_dp    <= bus.dp_mask;
                pend_valid <= 1'b1;
            end else if (wrap && pend_valid) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
            end

            an_q  <= show ? an_sel : '1;
            seg_q <= show ? {~dp_pad[idx], seg_of(nib)} : 8'hFF;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.digit_idx   = idx;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, CLK_DIV=4, GUARD=1.
// Time t counts rising edges since reset release.
module tb_seven_seg_scanner;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS(N),
        .CLK_DIV(4),
        .GUARD(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;

    logic [15:0] cur_v, pend_v;
    logic [3:0]  cur_dp, pend_dp;
    logic        pv;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic [2:0]  e_idx;
    logic        e_fs;

    logic [7:0] lut [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic blank_of(int d, logic [15:0] v, logic [3:0] dp);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < N; j++)
            if (v[4*j +: 4] != 4'h0 || dp[j]) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        t = 0; cur_v = '0; cur_dp = '0; pend_v = '0; pend_dp = '0; pv = 1'b0;
    endtask

    task automatic step();
        int d, p;
        logic en, ld, wrap;
        logic [7:0] b;
        @(posedge clk);
        en = bus.enable;
        ld = bus.load;
        t++;
        d = ((t - 1) / 4) % 4;
        p = (t - 1) % 4;
        if (en && p >= 1 && !blank_of(d, cur_v, cur_dp)) begin
            e_an = ~(4'b0001 << d);
            b = lut[cur_v[4*d +: 4]];
            e_seg = {~cur_dp[d], b[6:0]};
        end else begin
            e_an = 4'hF;
            e_seg = 8'hFF;
        end
        e_idx = 3'((t / 4) % 4);
        e_fs = (t % 16 == 0);
        wrap = (t % 16 == 0);
        if (ld && wrap) begin
            cur_v = bus.value; cur_dp = bus.dp_mask; pv = 1'b0;
        end else if (ld) begin
            pend_v = bus.value; pend_dp = bus.dp_mask; pv = 1'b1;
        end else if (wrap && pv) begin
            cur_v = pend_v; cur_dp = pend_dp; pv = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic step_check(string tag);
        step();
        checks++;
        if (bus.an !== e_an) begin
            errors++;
            $display("FAIL %s an t=%0d got %b want %b", tag, t, bus.an, e_an);
        end
        checks++;
        if (bus.seg !== e_seg) begin
            errors++;
            $display("FAIL %s seg t=%0d got %h want %h", tag, t, bus.seg, e_seg);
        end
        checks++;
        if (bus.digit_idx !== e_idx) begin
            errors++;
            $display("FAIL %s idx t=%0d got %0d want %0d", tag, t, bus.digit_idx, e_idx);
        end
        checks++;
        if (bus.frame_start !== e_fs) begin
            errors++;
            $display("FAIL %s fs t=%0d got %b want %b", tag, t, bus.frame_start, e_fs);
        end
    endtask

    task automatic run_to(int target, string tag);
        while (t < target) step_check(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1; bus.load = 1'b0;
        bus.value = '0; bus.dp_mask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.seg !== 8'hFF) begin
            errors++; $display("FAIL reset_seg got %h want FF", bus.seg);
        end
        checks++;
        if (bus.an !== 4'hF) begin
            errors++; $display("FAIL reset_an got %b want 1111", bus.an);
        end
        checks++;
        if (bus.digit_idx !== 3'd0) begin
            errors++; $display("FAIL reset_idx got %0d want 0", bus.digit_idx);
        end
        checks++;
        if (bus.frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_fs got %b want 0", bus.frame_start);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        while (t < 32) begin
            step_check("scan");
            checks++;
            if (t == 1 && bus.an !== 4'hF) begin
                errors++; $display("FAIL scan_first got %b want 1111", bus.an);
            end
            if (t == 2 && (bus.an !== 4'b1110 || bus.seg !== 8'hC0)) begin
                errors++;
                $display("FAIL scan_t2 got %b/%h want 1110/C0", bus.an, bus.seg);
            end
            if ((t == 16 || t == 32) && bus.frame_start !== 1'b1) begin
                errors++; $display("FAIL scan_fs t=%0d got 0 want 1", t);
            end
        end
    endtask

    task automatic test_load();
        int low0;
        run_to(37, "load");
        bus.value = 16'h12AF; bus.dp_mask = 4'b0000; bus.load = 1'b1;
        step_check("load");
        bus.load = 1'b0;
        run_to(46, "load");
        checks++;
        if (bus.an !== 4'b0111 || bus.seg !== 8'hC0) begin
            errors++; $display("FAIL load_hold got %b/%h want 0111/C0", bus.an, bus.seg);
        end
        run_to(48, "load");
        low0 = 0;
        while (t < 64) begin
            step_check("load");
            if (t >= 49 && t <= 52 && bus.an == 4'b1110) low0++;
            checks++;
            case (t)
                50: if (bus.an !== 4'b1110 || bus.seg !== 8'h8E) begin
                    errors++; $display("FAIL load_d0 got %b/%h want 1110/8E", bus.an, bus.seg);
                end
                54: if (bus.an !== 4'b1101 || bus.seg !== 8'h88) begin
                    errors++; $display("FAIL load_d1 got %b/%h want 1101/88", bus.an, bus.seg);
                end
                58: if (bus.an !== 4'b1011 || bus.seg !== 8'hA4) begin
                    errors++; $display("FAIL load_d2 got %b/%h want 1011/A4", bus.an, bus.seg);
                end
                62: if (bus.an !== 4'b0111 || bus.seg !== 8'hF9) begin
                    errors++; $display("FAIL load_d3 got %b/%h want 0111/F9", bus.an, bus.seg);
                end
                default: ;
            endcase
        end
        checks++;
        if (low0 != 3) begin
            errors++; $display("FAIL load_low_cycles got %0d want 3", low0);
        end
    endtask

    task automatic test_back_to_back();
        run_to(67, "b2b");
        bus.value = 16'h1111; bus.load = 1'b1;
        step_check("b2b");
        bus.load = 1'b0;
        run_to(71, "b2b");
        bus.value = 16'h2222; bus.load = 1'b1;
        step_check("b2b");
        bus.load = 1'b0;
        run_to(80, "b2b");
        while (t < 96) begin
            step_check("b2b");
            checks++;
            if (bus.an !== 4'hF && bus.seg !== 8'hA4) begin
                errors++; $display("FAIL b2b_newest t=%0d got %h want A4", t, bus.seg);
            end
        end
        run_to(111, "b2b");
        bus.value = 16'h0000; bus.dp_mask = 4'b0100; bus.load = 1'b1;
        step_check("wrapload");
        bus.load = 1'b0;
        while (t < 128) begin
            step_check("dp");
            checks++;
            case (t)
                114: if (bus.an !== 4'b1110 || bus.seg !== 8'hC0) begin
                    errors++; $display("FAIL dp_d0 got %b/%h want 1110/C0", bus.an, bus.seg);
                end
                118: if (bus.an !== 4'b1101 || bus.seg !== 8'hC0) begin
                    errors++; $display("FAIL dp_d1 got %b/%h want 1101/C0", bus.an, bus.seg);
                end
                122: if (bus.an !== 4'b1011 || bus.seg !== 8'h40) begin
                    errors++; $display("FAIL dp_d2 got %b/%h want 1011/40", bus.an, bus.seg);
                end
`ifdef LEADING_ZERO_BLANK_EN
                126: if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
                    errors++; $display("FAIL dp_d3 got %b/%h want 1111/FF", bus.an, bus.seg);
                end
`else
                126: if (bus.an !== 4'b0111 || bus.seg !== 8'hC0) begin
                    errors++; $display("FAIL dp_d3 got %b/%h want 0111/C0", bus.an, bus.seg);
                end
`endif
                default: ;
            endcase
        end
    endtask

    task automatic test_enable();
        run_to(130, "en");
        bus.enable = 1'b0;
        repeat (6) begin
            step_check("en_off");
            checks++;
            if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
                errors++; $display("FAIL en_blank t=%0d got %b/%h want 1111/FF", t, bus.an, bus.seg);
            end
        end
        bus.enable = 1'b1;
        run_to(138, "en");
        checks++;
        if (bus.an !== 4'b1011 || bus.seg !== 8'h40 || bus.digit_idx !== 3'd2) begin
            errors++;
            $display("FAIL en_resume got %b/%h/%0d want 1011/40/2", bus.an, bus.seg, bus.digit_idx);
        end
    endtask

    task automatic test_async_reset();
        run_to(139, "arst");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF || bus.digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL arst_blank got %b/%h/%0d want 1111/FF/0", bus.an, bus.seg, bus.digit_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_to(20, "arst");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
